// File: rtl/matvec_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matvec_pipe_ctrl
// Purpose  : Sequencing controller for an N x N matrix-vector datapath.
//            Streams an optional N*N weight matrix and then an N-element vector
//            into the weight / vector memories. It then issues row-by-row
//            multiply-accumulate reads, with en_acc/clear_acc delayed to match
//            the multiplier pipeline. One result per row is presented over a
//            valid/ready output.
// Revision : 1.0 - initial release (generalised N, pipelined multiplier)
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   input_valid  in   input element present
//   new_matrix   in   sampled with the first accepted element; 1 = weights first
//   input_ready  out  controller accepting an element
//   output_ready in   downstream accepts the current row result
//   output_valid out  accumulator holds a finished row result
//   addr_w       out  weight memory address (write and read)
//   wr_en_w      out  weight write strobe
//   addr_x       out  vector memory address (write and read)
//   wr_en_x      out  vector write strobe
//   clear_acc    out  accumulator loads the product instead of adding
//   en_acc       out  accumulator update
//   busy         out  high in every state except START
// ============================================================================
module matvec_pipe_ctrl #(
  parameter  int N       = 3,
  parameter  int MAC_LAT = 1,
  localparam int AW      = $clog2(N*N),
  localparam int AXW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           input_valid,
  input  logic           new_matrix,
  output logic           input_ready,
  input  logic           output_ready,
  output logic           output_valid,
  output logic [AW-1:0]  addr_w,
  output logic           wr_en_w,
  output logic [AXW-1:0] addr_x,
  output logic           wr_en_x,
  output logic           clear_acc,
  output logic           en_acc,
  output logic           busy
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_WAIT   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_LOAD_W = 3'd2;
  localparam logic [2:0] c_ST_LOAD_X = 3'd3;
  localparam logic [2:0] c_ST_ISSUE  = 3'd4;
  localparam logic [2:0] c_ST_DRAIN  = 3'd5;
  localparam logic [2:0] c_ST_OUTPUT = 3'd6;

  localparam logic [AW-1:0]  c_W_LAST     = AW'(N*N - 1);
  localparam logic [AXW-1:0] c_X_LAST     = AXW'(N - 1);
  localparam bit             c_HAS_LAT    = (MAC_LAT > 0);
  localparam logic [1:0]     c_DRAIN_LAST = (MAC_LAT > 0) ? 2'(MAC_LAT - 1) : 2'd0;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0]     r_state;
  logic [2:0]     w_state_nxt;
  logic [AW-1:0]  r_wcnt;
  logic [AXW-1:0] r_xcnt;
  logic [AXW-1:0] r_row;
  logic [AXW-1:0] r_k;
  logic [1:0]     r_dcnt;
  logic           r_w_loaded;
  logic [AW-1:0]  r_addr_w_q;
  logic [AXW-1:0] r_addr_x_q;

  logic           w_accept;
  logic           w_take_w;
  logic           w_issue;
  logic           w_first;
  logic [AW-1:0]  w_issue_addr;

  assign w_accept     = input_valid & input_ready;
  // A transaction must load weights if asked to, or if none are held yet.
  assign w_take_w     = new_matrix | ~r_w_loaded;
  assign w_issue_addr = AW'(int'(r_row) * N + int'(r_k));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_WAIT: begin
        w_state_nxt = c_ST_START;
      end
      c_ST_START: begin
        if (w_accept) begin
          w_state_nxt = w_take_w ? c_ST_LOAD_W : c_ST_LOAD_X;
        end
      end
      c_ST_LOAD_W: begin
        if (w_accept && (r_wcnt == c_W_LAST)) begin
          w_state_nxt = c_ST_LOAD_X;
        end
      end
      c_ST_LOAD_X: begin
        if (w_accept && (r_xcnt == c_X_LAST)) begin
          w_state_nxt = c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (r_k == c_X_LAST) begin
          w_state_nxt = c_HAS_LAT ? c_ST_DRAIN : c_ST_OUTPUT;
        end
      end
      c_ST_DRAIN: begin
        if (r_dcnt == c_DRAIN_LAST) begin
          w_state_nxt = c_ST_OUTPUT;
        end
      end
      c_ST_OUTPUT: begin
        if (output_ready) begin
          w_state_nxt = (r_row == c_X_LAST) ? c_ST_START : c_ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = c_ST_WAIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Addresses default to their previous value so that idle
  // cycles never show X and never glitch the memories' address lines.
  // --------------------------------------------------------------------------
  always_comb begin
    input_ready  = 1'b0;
    output_valid = 1'b0;
    wr_en_w      = 1'b0;
    wr_en_x      = 1'b0;
    w_issue      = 1'b0;
    w_first      = 1'b0;
    addr_w       = r_addr_w_q;
    addr_x       = r_addr_x_q;
    case (r_state)
      c_ST_START: begin
        input_ready = 1'b1;
        if (input_valid) begin
          if (w_take_w) begin
            wr_en_w = 1'b1;
            addr_w  = '0;
          end else begin
            wr_en_x = 1'b1;
            addr_x  = '0;
          end
        end
      end
      c_ST_LOAD_W: begin
        input_ready = 1'b1;
        if (input_valid) begin
          wr_en_w = 1'b1;
          addr_w  = r_wcnt;
        end
      end
      c_ST_LOAD_X: begin
        input_ready = 1'b1;
        if (input_valid) begin
          wr_en_x = 1'b1;
          addr_x  = r_xcnt;
        end
      end
      c_ST_ISSUE: begin
        w_issue = 1'b1;
        w_first = (r_k == '0);
        addr_w  = w_issue_addr;
        addr_x  = r_k;
      end
      c_ST_OUTPUT: begin
        output_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // During reset the state is WAIT, which is not START; gate with rst so
  // busy reads 0 while reset is held.
  assign busy = rst & (r_state != c_ST_START);

  // --------------------------------------------------------------------------
  // Counters and weight-loaded flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt     <= '0;
      r_xcnt     <= '0;
      r_row      <= '0;
      r_k        <= '0;
      r_dcnt     <= '0;
      r_w_loaded <= 1'b0;
    end else begin
      case (r_state)
        c_ST_START: begin
          if (w_accept) begin
            if (w_take_w) begin
              r_wcnt <= AW'(1);
            end else begin
              r_xcnt <= AXW'(1);
            end
          end
        end
        c_ST_LOAD_W: begin
          if (w_accept) begin
            if (r_wcnt == c_W_LAST) begin
              r_w_loaded <= 1'b1;
              r_xcnt     <= '0;
            end else begin
              r_wcnt <= r_wcnt + AW'(1);
            end
          end
        end
        c_ST_LOAD_X: begin
          if (w_accept) begin
            if (r_xcnt == c_X_LAST) begin
              r_row <= '0;
              r_k   <= '0;
            end else begin
              r_xcnt <= r_xcnt + AXW'(1);
            end
          end
        end
        c_ST_ISSUE: begin
          r_dcnt <= '0;
          if (r_k != c_X_LAST) begin
            r_k <= r_k + AXW'(1);
          end
        end
        c_ST_DRAIN: begin
          r_dcnt <= r_dcnt + 2'd1;
        end
        c_ST_OUTPUT: begin
          if (output_ready) begin
            r_k <= '0;
            if (r_row != c_X_LAST) begin
              r_row <= r_row + AXW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Address hold registers: capture whatever was driven this cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_w_q <= '0;
      r_addr_x_q <= '0;
    end else begin
      r_addr_w_q <= addr_w;
      r_addr_x_q <= addr_x;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator control delay: matches the multiplier pipeline so that the
  // accumulator sees each product together with its enable / clear flag.
  // --------------------------------------------------------------------------
  generate
    if (MAC_LAT == 0) begin : g_lat0
      assign en_acc    = w_issue;
      assign clear_acc = w_first;
    end else begin : g_lat_pipe
      logic [MAC_LAT-1:0] r_s_pipe;
      logic [MAC_LAT-1:0] r_c_pipe;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s_pipe <= '0;
          r_c_pipe <= '0;
        end else begin
          r_s_pipe[0] <= w_issue;
          r_c_pipe[0] <= w_first;
          for (int i = 1; i < MAC_LAT; i++) begin
            r_s_pipe[i] <= r_s_pipe[i-1];
            r_c_pipe[i] <= r_c_pipe[i-1];
          end
        end
      end

      assign en_acc    = r_s_pipe[MAC_LAT-1];
      assign clear_acc = r_c_pipe[MAC_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire
